// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared CPU pipeline constants for hazard control
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE    = 2'd3;
    localparam int         CNT_W        = 5;
    localparam int         MULT_CYC_DEF = 5;
    localparam int         DIV_CYC_DEF  = 10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_t;

    // Register 0 is hardwired and an unused operand can never be waited on.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// rtl/pipe_hazard_ctrl_md_busy_cnt.sv - multiply/divide unit busy down-counter
module md_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_is_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] r_cnt;

    // A new start always overrides whatever is still counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_is_div ? L_DIV : L_MULT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush control for a five-stage pipeline
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] E_wa,
    input  logic [4:0] M_wa,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    input  logic       D_md_use,
    input  logic       M_exc,
    output logic       stall_F,
    output logic       stall_FD,
    output logic       bubble_DE,
    output logic       flush_all,
    output logic       md_busy
);

    hz_state_t r_state;
    logic      w_haz_e;
    logic      w_haz_m;
    logic      w_haz_md;
    logic      w_stall;
    logic      w_md_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= M_exc ? ST_FLUSH : ST_RUN;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign w_haz_e  = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew)
                    | src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew);
    assign w_haz_m  = src_hazard(D_rs, D_tuse_rs, M_wa, M_tnew)
                    | src_hazard(D_rt, D_tuse_rt, M_wa, M_tnew);
    assign w_haz_md = D_md_use & (md_busy | E_md_start);
    assign w_stall  = w_haz_e | w_haz_m | w_haz_md;

    // Exceptions in the second flush cycle are ignored; flush beats stall.
    assign flush_all = (M_exc & (r_state == ST_RUN)) | (r_state == ST_FLUSH);
    assign stall_F   = w_stall & ~flush_all & ~M_exc;
    assign stall_FD  = stall_F;
    assign bubble_DE = stall_F;

    assign w_md_load = E_md_start & ~M_exc & ~flush_all;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_md_load),
        .i_is_div (E_md_is_div),
        .o_busy   (md_busy)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       E_md_start, E_md_is_div, D_md_use, M_exc;
    logic       stall_F, stall_FD, bubble_DE, flush_all, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_busy_left  = 0;
    int m_flush_left = 0;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_tuse_rs   (D_tuse_rs),
        .D_tuse_rt   (D_tuse_rt),
        .E_wa        (E_wa),
        .M_wa        (M_wa),
        .E_tnew      (E_tnew),
        .M_tnew      (M_tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .D_md_use    (D_md_use),
        .M_exc       (M_exc),
        .stall_F     (stall_F),
        .stall_FD    (stall_FD),
        .bubble_DE   (bubble_DE),
        .flush_all   (flush_all),
        .md_busy     (md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
        E_md_start = 0; E_md_is_div = 0; D_md_use = 0; M_exc = 0;
    endtask

    // advance to the next cycle; inputs are driven 1 time unit after the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic exp_stall,
                              input logic exp_flush, input logic exp_busy);
        #1;
        n_checks++;
        if ({stall_F, stall_FD, bubble_DE} !== {3{exp_stall}}) begin
            n_fail++;
            $display("FAIL %s stall: got %b%b%b expected %b", name, stall_F, stall_FD, bubble_DE, exp_stall);
        end
        n_checks++;
        if (flush_all !== exp_flush) begin
            n_fail++;
            $display("FAIL %s flush_all: got %b expected %b", name, flush_all, exp_flush);
        end
        n_checks++;
        if (md_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s md_busy: got %b expected %b", name, md_busy, exp_busy);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        m_busy_left = 0;
        m_flush_left = 0;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 1;
        check_outs("reset_comb_stall", 1'b1, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_data_hazard();
        idle_inputs();
        D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 1;
        check_outs("haz_E_rs", 1'b1, 1'b0, 1'b0);
        E_tnew = 0;
        check_outs("haz_E_tnew0", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        E_tnew = 2;
        D_tuse_rs = 0;
        check_outs("reg0_exempt", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        D_rt = 9; D_tuse_rt = 1; M_wa = 9; M_tnew = 2;
        check_outs("haz_M_rt", 1'b1, 1'b0, 1'b0);
        D_tuse_rt = 3; M_tnew = 3;
        check_outs("tuse_none", 1'b0, 1'b0, 1'b0);
        D_tuse_rt = 2;
        check_outs("tuse_eq_tnew_minus1", 1'b1, 1'b0, 1'b0);
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_mdu_div();
        idle_inputs();
        E_md_start = 1; E_md_is_div = 1; D_md_use = 1;
        check_outs("div_c0", 1'b1, 1'b0, 1'b0);
        next_cycle();
        E_md_start = 0; E_md_is_div = 0;
        for (int c = 1; c <= 10; c++) begin
            check_outs($sformatf("div_c%0d", c), 1'b1, 1'b0, 1'b1);
            next_cycle();
        end
        check_outs("div_c11", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        E_md_start = 1;
        next_cycle();
        E_md_start = 0;
        for (int c = 1; c <= 5; c++) begin
            check_outs($sformatf("mult_c%0d", c), 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        check_outs("mult_c6", 1'b0, 1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 1;
        M_exc = 1;
        check_outs("flush_c0", 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_outs("flush_c1", 1'b0, 1'b1, 1'b0);
        next_cycle();
        M_exc = 0;
        check_outs("flush_c2", 1'b1, 1'b0, 1'b0);
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_exc_start();
        idle_inputs();
        E_md_start = 1; M_exc = 1;
        check_outs("exc_start_c0", 1'b0, 1'b1, 1'b0);
        next_cycle();
        M_exc = 0;
        check_outs("exc_start_c1", 1'b0, 1'b1, 1'b0);
        next_cycle();
        E_md_start = 0;
        check_outs("exc_start_c2", 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_outs("exc_start_c3", 1'b0, 1'b0, 1'b0);
        E_md_start = 1;
        next_cycle();
        E_md_start = 0; M_exc = 1;
        check_outs("busy_through_exc", 1'b0, 1'b1, 1'b1);
        next_cycle();
        M_exc = 0;
        check_outs("busy_in_flush2", 1'b0, 1'b1, 1'b1);
        idle_inputs();
        repeat (6) next_cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        E_md_start = 1;
        next_cycle();
        E_md_start = 0; D_md_use = 1;
        repeat (3) next_cycle();
        check_outs("pre_reset_busy", 1'b1, 1'b0, 1'b1);
        #1 reset = 1'b0;
        check_outs("reset_mid", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            check_outs($sformatf("post_reset_%0d", c), 1'b0, 1'b0, 1'b0);
        end
        idle_inputs();
        do_reset();
    endtask

    task automatic test_random();
        logic exp_stall, exp_flush, exp_busy, hz;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            D_rs = 5'($urandom_range(0, 3));
            D_rt = 5'($urandom_range(0, 3));
            E_wa = 5'($urandom_range(0, 3));
            M_wa = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom_range(0, 3));
            D_tuse_rt = 2'($urandom_range(0, 3));
            E_tnew = 2'($urandom_range(0, 3));
            M_tnew = 2'($urandom_range(0, 3));
            E_md_start  = ($urandom_range(0, 7) == 0);
            E_md_is_div = 1'($urandom);
            D_md_use    = ($urandom_range(0, 2) == 0);
            M_exc       = ($urandom_range(0, 9) == 0);

            hz = 1'b0;
            if (D_rs != 0 && D_rs == E_wa && D_tuse_rs != 3 && D_tuse_rs < E_tnew) hz = 1'b1;
            if (D_rt != 0 && D_rt == E_wa && D_tuse_rt != 3 && D_tuse_rt < E_tnew) hz = 1'b1;
            if (D_rs != 0 && D_rs == M_wa && D_tuse_rs != 3 && D_tuse_rs < M_tnew) hz = 1'b1;
            if (D_rt != 0 && D_rt == M_wa && D_tuse_rt != 3 && D_tuse_rt < M_tnew) hz = 1'b1;
            if (D_md_use && (m_busy_left > 0 || E_md_start)) hz = 1'b1;
            exp_flush = (m_flush_left > 0) || M_exc;
            exp_stall = hz && !exp_flush && !M_exc;
            exp_busy  = (m_busy_left > 0);
            check_outs($sformatf("rand_%0d", c), exp_stall, exp_flush, exp_busy);

            if (E_md_start && !exp_flush) m_busy_left = E_md_is_div ? 10 : 5;
            else if (m_busy_left > 0) m_busy_left--;
            if (m_flush_left > 0) m_flush_left = 0;
            else if (M_exc) m_flush_left = 1;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_data_hazard();
        test_mdu_div();
        test_flush();
        test_exc_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles loaded for a mult/multu start.
REQ-002 Parameter DIV_CYC, default 10, busy cycles loaded for a div/divu start.
REQ-003 clk  in  1  single system clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 D_rs, D_rt  in  5 each  source register numbers of the instruction in D.
REQ-006 D_tuse_rs, D_tuse_rt  in  2 each  cycles until D instr needs rs/rt; 3 = operand unused.
REQ-007 E_wa, M_wa  in  5 each  destination register of the instr in E / M; 0 = no write.
REQ-008 E_tnew, M_tnew  in  2 each  cycles until that stage's result is forwardable.
REQ-009 E_md_start  in  1  mult/div instr in E issues to MDU this cycle.
REQ-010 E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
REQ-011 D_md_use  in  1  D instr reads or writes HI/LO or starts the MDU.
REQ-012 M_exc  in  1  exception/interrupt taken at M this cycle.
REQ-013 stall_F  out  1  hold PC register (drives its stall enable).
REQ-014 stall_FD  out  1  hold F/D pipeline register.
REQ-015 bubble_DE  out  1  load NOP into D/E register.
REQ-016 flush_all  out  1  clear F/D, D/E, E/M registers.
REQ-017 md_busy  out  1  MDU busy counter non-zero.

Function
REQ-018 Data hazard: haz_E = (D_rs!=0 && D_rs==E_wa && D_tuse_rs<E_tnew) or same for rt; haz_M identical with M_wa/M_tnew; tuse 3 never hazards.
REQ-019 MDU hazard: haz_MD = D_md_use && (md_busy || E_md_start).
REQ-020 stall = haz_E | haz_M | haz_MD, combinational, same cycle as inputs.
REQ-021 stall_F = stall_FD = bubble_DE = stall && !flush_all && !M_exc.
REQ-022 Busy counter (5 bits): on E_md_start && !M_exc && !flush_all load MULT_CYC or DIV_CYC per E_md_is_div; else if non-zero decrement by 1; saturates at 0.
REQ-023 md_busy = (counter != 0), registered; goes high the cycle after a start, low exactly N cycles after load of N.
REQ-024 An MDU op already counting continues through an exception; only a start in the exception cycle is suppressed.
REQ-025 E_md_start while counter non-zero: reload (new op overrides), no error state.
REQ-026 FSM states RUN, FLUSH; RUN->FLUSH on M_exc; FLUSH->RUN unconditionally next cycle; M_exc in FLUSH is ignored.
REQ-027 flush_all = M_exc (combinational, RUN only) | (state==FLUSH); total two consecutive flush cycles per exception.
REQ-028 Flush has priority over stall in the same cycle (REQ-021).

Reset
REQ-029 reset low asynchronously forces state=RUN, counter=0, md_busy=0, flush_all=0; stall outputs then follow REQ-021 combinationally.
REQ-030 Reset asserted mid-MDU-count or in FLUSH abandons the operation; no residual stall after release.

Structure
REQ-031 Tuse/Tnew encodings (TUSE_NONE=3), FSM state constants and default MULT_CYC/DIV_CYC live in the shared CPU constants package.
REQ-032 One sub-module md_busy_cnt (load/decrement counter, REQ-022..025); hazard compare and FSM stay in top.

Verification
REQ-033 D_rs=5,tuse_rs=0; E_wa=5,E_tnew=1 -> stall_F=stall_FD=bubble_DE=1 same cycle; E_tnew=0 -> all 0.
REQ-034 D_rs=0,E_wa=0,E_tnew=2,tuse=0 -> no stall (register 0 exempt).
REQ-035 E_md_start=1,is_div=1 at cycle 0 -> md_busy=1 cycles 1..10, 0 at cycle 11; D_md_use=1 stalls cycles 0..10 only.
REQ-036 M_exc=1 at cycle 0 with haz_E active -> flush_all=1 cycles 0 and 1, stall outputs 0 both cycles, M_exc at cycle 1 does not extend flush.
REQ-037 E_md_start with M_exc same cycle -> counter stays 0, md_busy never rises.
REQ-038 reset low at cycle 4 of a mult count -> md_busy=0 immediately, stays 0 after release with no new start.
